// File: rtl/decode_disp_imm_collector_pkg.sv
// Shared decode definitions: one-hot field lengths, full-length byte counts,
// collector FSM states and length helper functions.
package decode_disp_imm_collector_pkg;

  typedef enum logic [3:0] {
    LEN_8    = 4'b0001,
    LEN_16   = 4'b0010,
    LEN_32   = 4'b0100,
    LEN_FULL = 4'b1000
  } len_oh_e;

  localparam logic [3:0] DISP_FULL_BYTES = 4'd4;
  localparam logic [3:0] IMM_FULL_BYTES  = 4'd6;   // ptr16:32 far pointer

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISP,
    ST_IMM,
    ST_DONE
  } state_e;

  // Exactly one length bit set.
  function automatic logic len_is_valid(input logic [3:0] len);
    return (len != 4'd0) && ((len & (len - 4'd1)) == 4'd0);
  endfunction

  // Byte count of a one-hot length; "full" maps to the field's own full size.
  function automatic logic [3:0] len_to_bytes(input logic [3:0] len,
                                              input logic [3:0] full_bytes);
    case (len)
      LEN_8:    return 4'd1;
      LEN_16:   return 4'd2;
      LEN_32:   return 4'd4;
      LEN_FULL: return full_bytes;
      default:  return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/decode_disp_imm_collector_assembler.sv
// Field byte assembler: takes up to the remaining bytes of the current field
// from the window each cycle and merges them little-endian into a 48-bit
// accumulator. Clears itself when the field completes so it can be reused.
module decode_field_assembler #(
  parameter int IN_BYTES = 4,
  parameter int CW       = $clog2(IN_BYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_active,
  input  logic [3:0]            i_target,
  input  logic [8*IN_BYTES-1:0] i_bytes,
  input  logic [CW-1:0]         i_count,
  output logic [CW-1:0]         o_take,
  output logic [47:0]           o_acc,
  output logic                  o_done
);

  logic [3:0]   r_offset;
  logic [47:0]  r_acc;
  logic [3:0]   w_rem;
  logic [3:0]   w_cnt4;
  logic [3:0]   w_take4;
  logic [127:0] w_pad;

  assign w_rem   = i_target - r_offset;
  assign w_cnt4  = 4'(i_count);
  assign w_take4 = !i_active ? 4'd0 : ((w_rem < w_cnt4) ? w_rem : w_cnt4);
  assign o_take  = CW'(w_take4);
  assign o_done  = i_active && ((r_offset + w_take4) == i_target);
  // Zero padding keeps every window byte index in range.
  assign w_pad   = 128'(i_bytes);

  // Merge this cycle's bytes into the accumulator at the running offset.
  always_comb begin
    o_acc = r_acc;
    for (int i = 0; i < 6; i++) begin
      if (i >= int'(r_offset) && i < int'(r_offset) + int'(w_take4))
        o_acc[8*i +: 8] = w_pad[8*(i - int'(r_offset)) +: 8];
    end
  end

  // Offset/accumulator; restart from zero on clear or field completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_offset <= 4'd0;
      r_acc    <= '0;
    end else if (i_clear || o_done) begin
      r_offset <= 4'd0;
      r_acc    <= '0;
    end else if (i_active) begin
      r_offset <= r_offset + w_take4;
      r_acc    <= o_acc;
    end
  end

endmodule

// File: rtl/decode_disp_imm_collector.sv
// Decode-stage displacement/immediate collector. Latches a stage-3 descriptor,
// gathers disp then imm bytes from the prefetch window over several cycles,
// extends them and presents one result to the execute queue.
module decode_disp_imm_collector
  import decode_disp_imm_collector_pkg::*;
#(
  parameter int IN_BYTES = 4,
  parameter int DISP_W   = 32,
  parameter int IMM_W    = 48,
  localparam int CW      = $clog2(IN_BYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_disp_present,
  input  logic [3:0]            req_disp_len,
  input  logic                  req_disp_sext,
  input  logic                  req_imm_present,
  input  logic [3:0]            req_imm_len,
  input  logic                  req_imm_sext,
  input  logic [8*IN_BYTES-1:0] win_bytes,
  input  logic [CW-1:0]         win_count,
  output logic [CW-1:0]         win_consume,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DISP_W-1:0]     out_displacement,
  output logic [IMM_W-1:0]      out_immediate,
  output logic [3:0]            out_byte_count,
  output logic                  out_len_error
);

  state_e              r_state, w_state_nxt;
  logic [3:0]          r_disp_bytes, r_imm_bytes;
  logic                r_disp_sext, r_imm_sext;
  logic [DISP_W-1:0]   r_disp;
  logic [IMM_W-1:0]    r_imm;
  logic [3:0]          r_count;
  logic                r_len_err;

  logic                w_accept, w_active, w_field_done, w_len_err;
  logic [3:0]          w_target, w_disp_bytes, w_imm_bytes;
  logic [CW-1:0]       w_take;
  logic [47:0]         w_acc;

  function automatic logic [31:0] ext_disp(input logic [47:0] acc,
                                           input logic [3:0] n, input logic sx);
    case (n)
      4'd1:    return {{24{sx & acc[7]}},  acc[7:0]};
      4'd2:    return {{16{sx & acc[15]}}, acc[15:0]};
      default: return acc[31:0];
    endcase
  endfunction

  // A 6-byte far pointer is taken as-is; shorter immediates extend to 48 bits.
  function automatic logic [47:0] ext_imm(input logic [47:0] acc,
                                          input logic [3:0] n, input logic sx);
    case (n)
      4'd1:    return {{40{sx & acc[7]}},  acc[7:0]};
      4'd2:    return {{32{sx & acc[15]}}, acc[15:0]};
      4'd4:    return {{16{sx & acc[31]}}, acc[31:0]};
      default: return acc;
    endcase
  endfunction

  // Malformed lengths collapse to a zero-byte field; absent fields never error.
  assign w_disp_bytes = (req_disp_present && len_is_valid(req_disp_len))
                        ? len_to_bytes(req_disp_len, DISP_FULL_BYTES) : 4'd0;
  assign w_imm_bytes  = (req_imm_present && len_is_valid(req_imm_len))
                        ? len_to_bytes(req_imm_len, IMM_FULL_BYTES) : 4'd0;
  assign w_len_err    = (req_disp_present && !len_is_valid(req_disp_len)) ||
                        (req_imm_present  && !len_is_valid(req_imm_len));
  assign w_accept     = (r_state == ST_IDLE) && req_valid && !flush;

  decode_field_assembler #(.IN_BYTES(IN_BYTES), .CW(CW)) u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (flush),
    .i_active (w_active),
    .i_target (w_target),
    .i_bytes  (win_bytes),
    .i_count  (win_count),
    .o_take   (w_take),
    .o_acc    (w_acc),
    .o_done   (w_field_done)
  );

  assign win_consume      = w_take;
  assign out_displacement = r_disp;
  assign out_immediate    = r_imm;
  assign out_byte_count   = r_count;
  assign out_len_error    = r_len_err;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, handshakes and which field the assembler is working on.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    out_valid   = 1'b0;
    w_active    = 1'b0;
    w_target    = 4'd0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          w_state_nxt = (w_disp_bytes != 4'd0) ? ST_DISP :
                        (w_imm_bytes  != 4'd0) ? ST_IMM  : ST_DONE;
      end
      ST_DISP: begin
        w_active = 1'b1;
        w_target = r_disp_bytes;
        if (w_field_done)
          w_state_nxt = (r_imm_bytes != 4'd0) ? ST_IMM : ST_DONE;
      end
      ST_IMM: begin
        w_active = 1'b1;
        w_target = r_imm_bytes;
        if (w_field_done) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Flush wins: nothing is taken from the window and we return to IDLE.
    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_active    = 1'b0;
    end
  end

  // Descriptor latch on accept; result capture on each field's completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_bytes <= 4'd0;
      r_imm_bytes  <= 4'd0;
      r_disp_sext  <= 1'b0;
      r_imm_sext   <= 1'b0;
      r_disp       <= '0;
      r_imm        <= '0;
      r_count      <= 4'd0;
      r_len_err    <= 1'b0;
    end else if (flush) begin
      r_count      <= 4'd0;
    end else if (w_accept) begin
      r_disp_bytes <= w_disp_bytes;
      r_imm_bytes  <= w_imm_bytes;
      r_disp_sext  <= req_disp_sext;
      r_imm_sext   <= req_imm_sext;
      r_disp       <= '0;
      r_imm        <= '0;
      r_count      <= 4'd0;
      r_len_err    <= w_len_err;
    end else if (w_active) begin
      r_count <= r_count + 4'(w_take);
      if (w_field_done) begin
        if (r_state == ST_DISP) r_disp <= ext_disp(w_acc, r_disp_bytes, r_disp_sext);
        else                    r_imm  <= ext_imm(w_acc, r_imm_bytes, r_imm_sext);
      end
    end
  end

endmodule

// File: tb/tb_decode_disp_imm_collector.sv
// Bench for decode_disp_imm_collector: a byte-stream prefetch model feeds the
// window; expected results come from slicing the stream per the length rules.
module tb_decode_disp_imm_collector;

  localparam int IN_BYTES = 4;
  localparam int CW       = $clog2(IN_BYTES + 1);

  logic                  clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic                  req_valid = 1'b0, req_ready;
  logic                  req_disp_present = 1'b0, req_disp_sext = 1'b0;
  logic                  req_imm_present = 1'b0, req_imm_sext = 1'b0;
  logic [3:0]            req_disp_len = 4'd0, req_imm_len = 4'd0;
  logic [8*IN_BYTES-1:0] win_bytes = '0;
  logic [CW-1:0]         win_count = '0, win_consume;
  logic                  out_valid, out_ready = 1'b0, out_len_error;
  logic [31:0]           out_displacement;
  logic [47:0]           out_immediate;
  logic [3:0]            out_byte_count;

  always #5 clk = ~clk;

  decode_disp_imm_collector #(.IN_BYTES(IN_BYTES), .DISP_W(32), .IMM_W(48)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_disp_present(req_disp_present), .req_disp_len(req_disp_len),
    .req_disp_sext(req_disp_sext),
    .req_imm_present(req_imm_present), .req_imm_len(req_imm_len),
    .req_imm_sext(req_imm_sext),
    .win_bytes(win_bytes), .win_count(win_count), .win_consume(win_consume),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_displacement(out_displacement), .out_immediate(out_immediate),
    .out_byte_count(out_byte_count), .out_len_error(out_len_error)
  );

  int            n_cmp = 0, n_mis = 0;
  byte unsigned  stream[$];
  byte unsigned  fixed[$];
  int            wmode = 0;
  bit            tog = 1'b0;
  logic [31:0]   e_disp;
  logic [47:0]   e_imm;
  int            e_cnt, e_lat;
  bit            e_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Prefetch window: 0 = full, 1 = random count, 2 = alternating 1/0 bytes.
  task automatic drive_window();
    int lim, n;
    tog = ~tog;
    case (wmode)
      0:       lim = IN_BYTES;
      1:       lim = int'($urandom_range(0, IN_BYTES));
      default: lim = tog ? 1 : 0;
    endcase
    n = (stream.size() < lim) ? stream.size() : lim;
    for (int k = 0; k < IN_BYTES; k++)
      win_bytes[8*k +: 8] = (k < n) ? stream[k] : 8'($urandom);
    win_count = CW'(n);
  endtask

  // Called at a negedge: note the take, cross the posedge, retire taken bytes.
  task automatic edge_from_negedge();
    int c;
    c = int'(win_consume);
    chk("consume_le_count", 64'(win_consume <= win_count), 64'd1);
    @(posedge clk); #1;
    for (int k = 0; k < c; k++) if (stream.size() > 0) void'(stream.pop_front());
    drive_window();
  endtask

  task automatic step();
    @(negedge clk);
    edge_from_negedge();
  endtask

  function automatic int fbytes(input bit p, input logic [3:0] len, input int full);
    if (!p) return 0;
    case (len)
      4'b0001: return 1;
      4'b0010: return 2;
      4'b0100: return 4;
      4'b1000: return full;
      default: return 0;
    endcase
  endfunction

  // Two's-complement extension of an n-byte value to w bits when narrower.
  function automatic longint unsigned extend(input longint unsigned v, input int n,
                                             input bit sx, input int w);
    longint unsigned r = v;
    if (sx && n > 0 && 8*n < w && v[8*n-1]) r = v - (64'd1 << (8*n));
    return r & ((64'd1 << w) - 64'd1);
  endfunction

  // Build the byte stream for one instruction and the expected result.
  task automatic set_req(input bit dp, input logic [3:0] dl, input bit ds,
                         input bit ip, input logic [3:0] il, input bit is);
    int nd, ni;
    longint unsigned vd, vi;
    nd = fbytes(dp, dl, 4);
    ni = fbytes(ip, il, 6);
    stream.delete();
    for (int k = 0; k < nd + ni; k++)
      stream.push_back((fixed.size() > 0) ? fixed.pop_front() : 8'($urandom));
    vd = 0; vi = 0;
    for (int k = 0; k < nd; k++) vd |= longint'(stream[k]) << (8*k);
    for (int k = 0; k < ni; k++) vi |= longint'(stream[nd+k]) << (8*k);
    e_disp = 32'(extend(vd, nd, ds, 32));
    e_imm  = 48'(extend(vi, ni, is, 48));
    e_cnt  = nd + ni;
    e_err  = (dp && $countones(dl) != 1) || (ip && $countones(il) != 1);
    e_lat  = 1 + (nd + IN_BYTES - 1) / IN_BYTES + (ni + IN_BYTES - 1) / IN_BYTES;
    for (int k = 0; k < 3; k++) stream.push_back(8'($urandom));
    req_disp_present = dp; req_disp_len = dl; req_disp_sext = ds;
    req_imm_present  = ip; req_imm_len  = il; req_imm_sext  = is;
    drive_window();
  endtask

  // From posedge+1: offer the descriptor, cross the accepting edge, scramble req_*.
  task automatic accept();
    req_valid = 1'b1;
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_disp_present = 1'($urandom); req_disp_len = 4'($urandom); req_disp_sext = 1'($urandom);
    req_imm_present  = 1'($urandom); req_imm_len  = 4'($urandom); req_imm_sext  = 1'($urandom);
    drive_window();
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_disp"},  64'(out_displacement), 64'(e_disp));
    chk({tag, "_imm"},   64'(out_immediate), 64'(e_imm));
    chk({tag, "_count"}, 64'(out_byte_count), 64'(e_cnt));
    chk({tag, "_err"},   64'(out_len_error), 64'(e_err));
  endtask

  // Wait (bounded) for the result, check it, hold it, then release it.
  task automatic finish_instr(input bit chk_lat, input int hold);
    int cyc = 1;
    forever begin
      @(negedge clk);
      if (out_valid || cyc >= 60) break;
      edge_from_negedge();
      cyc++;
    end
    check_result("res");
    if (chk_lat) chk("latency", 64'(cyc), 64'(e_lat));
    chk("bytes_left", 64'(stream.size()), 64'd3);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      drive_window();
      @(negedge clk);
      check_result("hold");
      chk("hold_req_ready", 64'(req_ready), 64'd0);
      chk("hold_consume", 64'(win_consume), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive_window();
    @(negedge clk);
    chk("release_valid", 64'(out_valid), 64'd0);
    chk("release_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic run(input bit dp, input logic [3:0] dl, input bit ds,
                     input bit ip, input logic [3:0] il, input bit is,
                     input bit chk_lat, input int hold);
    set_req(dp, dl, ds, ip, il, is);
    accept();
    finish_instr(chk_lat, hold);
  endtask

  initial begin
    // Reset values with a full window on offer.
    for (int k = 0; k < IN_BYTES; k++) stream.push_back(8'($urandom));
    drive_window();
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_disp",      64'(out_displacement), 64'd0);
    chk("rst_imm",       64'(out_immediate), 64'd0);
    chk("rst_count",     64'(out_byte_count), 64'd0);
    chk("rst_err",       64'(out_len_error), 64'd0);
    chk("rst_consume",   64'(win_consume), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // disp8 0xF0 sign-extended, no imm.
    fixed = '{8'hF0};
    run(1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 0);
    // disp32 + imm16 zero-extended.
    fixed = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE};
    run(1'b1, 4'b0100, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b1, 2);
    // Far-pointer immediate trickled in one byte every other cycle.
    fixed = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hCD, 8'hAB};
    wmode = 2;
    run(1'b0, 4'b0000, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b0, 0);
    wmode = 0;
    // Malformed disp length, then a normal instruction.
    run(1'b1, 4'b0011, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 0);
    run(1'b1, 4'b0010, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 0);
    run(1'b1, 4'b0100, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 0);
    // Back-pressure held for five cycles.
    run(1'b1, 4'b1000, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b1, 5);

    // Flush in the middle of the immediate.
    wmode = 2;
    set_req(1'b0, 4'b0000, 1'b0, 1'b1, 4'b1000, 1'b0);
    accept();
    for (int k = 0; k < 4; k++) step();
    wmode = 0;
    drive_window();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_consume", 64'(win_consume), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // Flush alongside a request: the request must not be taken.
    set_req(1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0);
    req_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("flushreq_ready", 64'(req_ready), 64'd1);
    chk("flushreq_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of the displacement.
    wmode = 2;
    set_req(1'b1, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0);
    accept();
    for (int k = 0; k < 2; k++) step();
    rst_n = 1'b0;
    #1;
    chk("arst_ready",   64'(req_ready), 64'd1);
    chk("arst_valid",   64'(out_valid), 64'd0);
    chk("arst_consume", 64'(win_consume), 64'd0);
    chk("arst_count",   64'(out_byte_count), 64'd0);
    chk("arst_disp",    64'(out_displacement), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wmode = 0;
    run(1'b1, 4'b0100, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 0);

    // Random descriptors, lengths (sometimes malformed) and window fill.
    for (int t = 0; t < 40; t++) begin
      logic [3:0] dl, il;
      dl = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      il = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      wmode = int'($urandom_range(0, 1));
      run(1'($urandom), dl, 1'($urandom), 1'($urandom), il, 1'($urandom),
          wmode == 0, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
